// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell stepped over WIDTH cycles, LSB first.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
`ifdef SERIAL_ADD_OVF_EN
   output logic             done,
   output logic             ovf
`else
   output logic             done
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             s_bit;
   logic             c_bit;

   assign s_bit = a_sh[0] ^ b_sh[0] ^ carry;
   assign c_bit = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: operands are only touched on the accepting edge and in RUN,
   // so sum/cout hold through DONE and IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  sum_sh <= '0;
                  carry  <= cin;
                  cnt    <= '0;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               sum_sh <= (sum_sh >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
               carry  <= c_bit;
               cnt    <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   logic ovf_reg;

   // Overflow is the carry into the MSB differing from the carry out of it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_reg <= 1'b0;
      end else if (state_reg == IDLE && start) begin
         ovf_reg <= 1'b0;
      end else if (state_reg == RUN && cnt == LAST) begin
         ovf_reg <= carry ^ c_bit;
      end
   end

   assign ovf = ovf_reg;
`endif

   assign sum  = sum_sh;
   assign cout = carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: a WIDTH=8 and a WIDTH=1 instance checked against
// an arithmetic model every cycle, plus directed literal checks.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       cin8 = 1'b0;
   logic [7:0] sum8;
   logic       cout8, busy8, done8;
   logic       start1 = 1'b0;
   logic       a1 = 1'b0;
   logic       b1 = 1'b0;
   logic       cin1 = 1'b0;
   logic       sum1;
   logic       cout1, busy1, done1;
`ifdef SERIAL_ADD_OVF_EN
   logic       ovf8, ovf1;
`endif

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .sum(sum8), .cout(cout8), .busy(busy8),
`ifdef SERIAL_ADD_OVF_EN
      .done(done8), .ovf(ovf8)
`else
      .done(done8)
`endif
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .sum(sum1), .cout(cout1), .busy(busy1),
`ifdef SERIAL_ADD_OVF_EN
      .done(done1), .ovf(ovf1)
`else
      .done(done1)
`endif
   );

   task automatic check(input string name, input longint actual, input longint expected);
      checks++;
      if (actual == expected) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   // Model: per unit, the accepting edge number and the arithmetic result.
   int     wd[2] = '{8, 1};
   int     ecnt = 0;
   int     k_e[2];
   bit     act[2];
   longint res[2];
   bit     ov[2];

   task automatic model_accept(input int u, input longint av, input longint bv, input longint cv);
      longint t;
      int     w;
      w      = wd[u];
      t      = av + bv + cv;
      k_e[u] = ecnt;
      act[u] = 1'b1;
      res[u] = t & ((longint'(1) << (w + 1)) - 1);
      ov[u]  = (av[w-1] == bv[w-1]) && (t[w-1] != av[w-1]);
   endtask

   always @(posedge clk) begin
      ecnt = ecnt + 1;
      if (!reset) begin
         if (start8 && (!act[0] || ecnt - 1 >= k_e[0] + wd[0] + 1))
            model_accept(0, longint'(a8), longint'(b8), longint'(cin8));
         if (start1 && (!act[1] || ecnt - 1 >= k_e[1] + wd[1] + 1))
            model_accept(1, longint'(a1), longint'(b1), longint'(cin1));
      end
   end

   always @(posedge reset) begin
      for (int u = 0; u < 2; u++) begin
         act[u] = 1'b0;
         res[u] = 0;
         ov[u]  = 1'b0;
      end
   end

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         int     w;
         bit     eb, ed, fin;
         longint s_act, c_act, b_act, d_act;
         w   = wd[u];
         eb  = act[u] && ecnt >= k_e[u] && ecnt < k_e[u] + w;
         ed  = act[u] && ecnt == k_e[u] + w;
         fin = !act[u] || ecnt >= k_e[u] + w;
         s_act = (u == 0) ? longint'(sum8)  : longint'(sum1);
         c_act = (u == 0) ? longint'(cout8) : longint'(cout1);
         b_act = (u == 0) ? longint'(busy8) : longint'(busy1);
         d_act = (u == 0) ? longint'(done8) : longint'(done1);
         check($sformatf("busy_w%0d", w), b_act, longint'(eb));
         check($sformatf("done_w%0d", w), d_act, longint'(ed));
         if (fin) begin
            check($sformatf("sum_w%0d", w), s_act, res[u] & ((longint'(1) << w) - 1));
            check($sformatf("cout_w%0d", w), c_act, res[u] >> w);
`ifdef SERIAL_ADD_OVF_EN
            check($sformatf("ovf_w%0d", w), (u == 0) ? longint'(ovf8) : longint'(ovf1),
                  longint'(ov[u]));
`endif
         end
      end
   end

   // Launch one W8 addition and wait (bounded) for done; n = negedges until done.
   task automatic go8(input logic [7:0] av, input logic [7:0] bv, input logic cv, output int n);
      a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         start8 = 1'b0; a8 = ~av; b8 = ~bv; cin8 = ~cv;
      end while (!done8 && n < 40);
   endtask

   task automatic go1(input logic av, input logic bv, input logic cv, output int n);
      a1 = av; b1 = bv; cin1 = cv; start1 = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         start1 = 1'b0; a1 = ~av; b1 = ~bv; cin1 = ~cv;
      end while (!done1 && n < 40);
   endtask

   initial begin
      int n;
      int dcount;
      #1 reset = 1'b1;
      #2;
      check("rst_sum", longint'(sum8), 0);
      check("rst_busy", longint'(busy8), 0);
      check("rst_done", longint'(done8), 0);
      check("rst_cout", longint'(cout8), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      go8(8'h5A, 8'h3C, 1'b0, n);
      $display("add 5A+3C+0 -> sum=%h cout=%b latency=%0d", sum8, cout8, n);
      check("lat_5a3c", n, 9);
      check("sum_5a3c", longint'(sum8), 'h96);
      check("cout_5a3c", longint'(cout8), 0);
`ifdef SERIAL_ADD_OVF_EN
      check("ovf_5a3c", longint'(ovf8), 1);
`endif
      @(negedge clk);

      go8(8'hFF, 8'h01, 1'b0, n);
      $display("add FF+01+0 -> sum=%h cout=%b", sum8, cout8);
      check("sum_ff01", longint'(sum8), 'h00);
      check("cout_ff01", longint'(cout8), 1);
`ifdef SERIAL_ADD_OVF_EN
      check("ovf_ff01", longint'(ovf8), 0);
`endif
      @(negedge clk);

      go8(8'h00, 8'h00, 1'b1, n);
      $display("add 00+00+1 -> sum=%h cout=%b", sum8, cout8);
      check("sum_cin", longint'(sum8), 'h01);
      check("cout_cin", longint'(cout8), 0);
      @(negedge clk);

      // start re-pulsed during RUN and during DONE of 7F+01
      a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
      repeat (2) @(negedge clk);
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (5) @(negedge clk);
      $display("add 7F+01+0 -> sum=%h done=%b", sum8, done8);
      check("done_7f01", longint'(done8), 1);
      check("sum_7f01", longint'(sum8), 'h80);
`ifdef SERIAL_ADD_OVF_EN
      check("ovf_7f01", longint'(ovf8), 1);
`endif
      start8 = 1'b1;
      @(negedge clk);
      check("ignored_in_done", longint'(busy8), 0);
      @(negedge clk);
      check("accepted_in_idle", longint'(busy8), 1);
      start8 = 1'b0;
      n = 0;
      while (!done8 && n < 40) begin
         @(negedge clk);
         n++;
      end
      $display("add 11+22+0 -> sum=%h", sum8);
      check("sum_1122", longint'(sum8), 'h33);
      @(negedge clk);

      // reset in the middle of an addition
      a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      $display("reset mid-run -> busy=%b sum=%h", busy8, sum8);
      check("abort_busy", longint'(busy8), 0);
      check("abort_sum", longint'(sum8), 0);
      check("abort_cout", longint'(cout8), 0);
      check("abort_done", longint'(done8), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      go8(8'h10, 8'h20, 1'b0, n);
      $display("add 10+20+0 -> sum=%h", sum8);
      check("sum_1020", longint'(sum8), 'h30);
      @(negedge clk);

      // WIDTH=1 full-adder truth table
      for (int i = 0; i < 8; i++) begin
         int t;
         t = i[2] + i[1] + i[0];
         go1(i[2], i[1], i[0], n);
         $display("w1 %b+%b+%b -> sum=%b cout=%b latency=%0d", i[2], i[1], i[0], sum1, cout1, n);
         check("w1_lat", n, 2);
         check("w1_sum", longint'(sum1), t & 1);
         check("w1_cout", longint'(cout1), t >> 1);
         @(negedge clk);
      end

      // start held high: back-to-back additions, operands changing every cycle
      dcount = 0;
      start8 = 1'b1;
      for (int i = 0; i < 40; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         @(negedge clk);
         if (done8) dcount++;
      end
      start8 = 1'b0;
      $display("back-to-back -> %0d dones in 40 cycles", dcount);
      check("b2b_dones", dcount, 4);
      repeat (12) @(negedge clk);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
